bram_port_arbiter: RTL and testbench

//   Shares one single-port block RAM (2048 x 16, 1-cycle registered read, read-first) between two requesters, A and B.

---
 rtl/bram_port_arbiter.sv | 125 ++++++++++++
 tb/tb_bram_port_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port BRAM.
// Bounded bursts; read data is routed back to the requester that issued the read.
module bram_port_arbiter #(
   parameter int AW        = 11,
   parameter int DW        = 16,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_din,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_din,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] BMAX = CW'(MAX_BURST);
   localparam logic [CW-1:0] BONE = CW'(1);
   localparam logic OWN_A = 1'b0;
   localparam logic OWN_B = 1'b1;

   logic          last_owner_q, last_owner_d;
   logic [CW-1:0] burst_cnt_q, burst_cnt_d;
   logic          rd_pend_a_q, rd_pend_b_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_din_q;
   logic          gnt_a, gnt_b;
   logic          winner;

   // Grant decision: a zero count means no burst is running, so a tie
   // goes to the side that did not own the port last (A after reset).
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (!rst) begin
         if (a_req && !b_req) begin
            gnt_a = 1'b1;
         end else if (b_req && !a_req) begin
            gnt_b = 1'b1;
         end else if (a_req && b_req) begin
            if (burst_cnt_q == '0 || burst_cnt_q >= BMAX) begin
               gnt_a = (last_owner_q == OWN_B);
               gnt_b = (last_owner_q == OWN_A);
            end else begin
               gnt_a = (last_owner_q == OWN_A);
               gnt_b = (last_owner_q == OWN_B);
            end
         end
      end
   end

   // Burst bookkeeping: extend the run, hand over ownership, or clear on idle.
   always_comb begin
      winner       = gnt_b;
      last_owner_d = last_owner_q;
      burst_cnt_d  = '0;
      if (gnt_a || gnt_b) begin
         if (winner == last_owner_q) begin
            burst_cnt_d = (burst_cnt_q >= BMAX) ? BMAX : burst_cnt_q + BONE;
         end else begin
            last_owner_d = winner;
            burst_cnt_d  = BONE;
         end
      end
   end

   // BRAM port mux; address/data hold the last granted values when idle.
   always_comb begin
      mem_we   = 1'b0;
      mem_addr = mem_addr_q;
      mem_din  = mem_din_q;
      if (gnt_a) begin
         mem_we   = a_we;
         mem_addr = a_addr;
         mem_din  = a_din;
      end else if (gnt_b) begin
         mem_we   = b_we;
         mem_addr = b_addr;
         mem_din  = b_din;
      end
   end

   // Arbitration state, read-return tracking and held BRAM port values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_owner_q <= OWN_B;
         burst_cnt_q  <= '0;
         rd_pend_a_q  <= 1'b0;
         rd_pend_b_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
      end else begin
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         rd_pend_a_q  <= gnt_a & ~a_we;
         rd_pend_b_q  <= gnt_b & ~b_we;
         if (gnt_a || gnt_b) begin
            mem_addr_q <= mem_addr;
            mem_din_q  <= mem_din;
         end
      end
   end

   assign a_gnt    = gnt_a;
   assign b_gnt    = gnt_b;
   assign a_rvalid = rd_pend_a_q;
   assign b_rvalid = rd_pend_b_q;
   assign a_rdata  = mem_dout;
   assign b_rdata  = mem_dout;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter with a read-first BRAM model.
// Stimulus pushes expected grants/read data; a negedge monitor pops and compares.
module tb_bram_port_arbiter;

   localparam int AW = 11;
   localparam int DW = 16;

   logic          clk;
   logic          rst;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_din, b_din;
   logic          a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   logic [DW-1:0] ram [0:2047];

   int n_vec = 0;
   int n_bad = 0;

   bit            qg[$];
   logic [DW-1:0] qa[$];
   logic [DW-1:0] qb[$];

   bram_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-first single-port BRAM model
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Monitor: every grant and every rvalid consumes one expected entry
   always @(negedge clk) begin
      if (!rst) begin
         if (a_gnt && b_gnt) chk("dual_gnt", 1, 0);
         if (a_rvalid && b_rvalid) chk("dual_rvalid", 1, 0);
         if (a_gnt || b_gnt) begin
            if (qg.size() == 0) chk("unexpected_gnt", {31'd0, b_gnt}, 32'hdead);
            else chk("gnt_owner", {31'd0, b_gnt}, {31'd0, qg.pop_front()});
         end
         if (a_rvalid) begin
            if (qa.size() == 0) chk("unexpected_a_rvalid", 1, 0);
            else chk("a_rdata", {16'd0, a_rdata}, {16'd0, qa.pop_front()});
         end
         if (b_rvalid) begin
            if (qb.size() == 0) chk("unexpected_b_rvalid", 1, 0);
            else chk("b_rdata", {16'd0, b_rdata}, {16'd0, qb.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) ram[i] = '0;
      ram[11'h005] = 16'h1234;
      ram[11'h010] = 16'hAAAA;
      ram[11'h020] = 16'hBBBB;
      rst = 1'b1;
      a_req = 0; a_we = 0; a_addr = '0; a_din = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_din = '0;

      // Reset: requests held high, nothing may be granted
      tick(); tick();
      a_req = 1; b_req = 1;
      @(negedge clk);
      chk("rst_a_gnt", {31'd0, a_gnt}, 0);
      chk("rst_b_gnt", {31'd0, b_gnt}, 0);
      chk("rst_mem_we", {31'd0, mem_we}, 0);
      chk("rst_a_rvalid", {31'd0, a_rvalid}, 0);
      chk("rst_b_rvalid", {31'd0, b_rvalid}, 0);
      tick();
      a_req = 0; b_req = 0; rst = 0;

      // Single A read of 0x005
      tick();
      a_req = 1; a_we = 0; a_addr = 11'h005;
      qg.push_back(1'b0); qa.push_back(16'h1234);
      @(negedge clk);
      chk("t1_gnt_same_cycle", {31'd0, a_gnt}, 1);
      chk("t1_mem_addr", {21'd0, mem_addr}, 32'h005);
      chk("t1_mem_we", {31'd0, mem_we}, 0);
      tick();
      a_req = 0;
      @(negedge clk);
      chk("t1_idle_hold_addr", {21'd0, mem_addr}, 32'h005);
      tick(); tick();

      // Fresh reset, then contended reads: AAAABBBBAAAA
      rst = 1;
      tick();
      rst = 0;
      a_req = 1; a_addr = 11'h010; b_req = 1; b_we = 0; b_addr = 11'h020;
      for (int i = 0; i < 12; i++) begin
         if (((i / 4) % 2) == 0) begin
            qg.push_back(1'b0); qa.push_back(16'hAAAA);
         end else begin
            qg.push_back(1'b1); qb.push_back(16'hBBBB);
         end
      end
      repeat (12) tick();
      a_req = 0; b_req = 0;

      // B alone for 10 cycles: no forced gap
      b_addr = 11'h020; b_req = 1;
      for (int i = 0; i < 10; i++) begin
         qg.push_back(1'b1); qb.push_back(16'hBBBB);
      end
      repeat (10) tick();
      b_req = 0;
      tick();

      // A writes 0xBEEF to 0x7FF, B reads it next cycle
      a_req = 1; a_we = 1; a_addr = 11'h7FF; a_din = 16'hBEEF;
      qg.push_back(1'b0);
      @(negedge clk);
      chk("t5_mem_we", {31'd0, mem_we}, 1);
      chk("t5_mem_addr", {21'd0, mem_addr}, 32'h7FF);
      chk("t5_mem_din", {16'd0, mem_din}, 32'hBEEF);
      tick();
      a_req = 0; a_we = 0; a_din = '0;
      b_req = 1; b_addr = 11'h7FF;
      qg.push_back(1'b1); qb.push_back(16'hBEEF);
      tick();
      b_req = 0;
      @(negedge clk);
      chk("t5_idle_mem_we", {31'd0, mem_we}, 0);
      chk("t5_idle_addr", {21'd0, mem_addr}, 32'h7FF);
      tick();

      // B read, then reset the following cycle: read data is dropped
      b_req = 1; b_addr = 11'h020;
      qg.push_back(1'b1);
      tick();
      rst = 1; a_req = 1; a_addr = 11'h010;
      @(negedge clk);
      chk("t6_b_rvalid", {31'd0, b_rvalid}, 0);
      chk("t6_a_gnt", {31'd0, a_gnt}, 0);
      chk("t6_b_gnt", {31'd0, b_gnt}, 0);
      chk("t6_mem_we", {31'd0, mem_we}, 0);
      tick();
      rst = 0;
      qg.push_back(1'b0); qa.push_back(16'hAAAA);
      @(negedge clk);
      chk("t6_tie_gnt_a", {31'd0, a_gnt}, 1);
      tick();
      a_req = 0; b_req = 0;

      // Drain: everything expected must have been seen
      repeat (4) tick();
      chk("drain_gnt", qg.size(), 0);
      chk("drain_a", qa.size(), 0);
      chk("drain_b", qb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
